// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - register-file dump controller sharing the core read port
//
// Walks register indices first_idx_i..last_idx_i (wrapping mod 32) and borrows
// the shared register-file read port for one cycle per index. It then emits one
// 40-bit frame {data, 3'b000, index} per register on a valid/ready interface.
//
// Parameters
//   READ_LAT    cycles from rf_addr_o presented to rf_data_i valid (1..4)
//   STARVE_MAX  consecutive denied request cycles before a forced grab (1..255)
//
// Ports
//   CLK            clock, rising edge
//   RESET          synchronous, active-high reset
//   start_i        single-cycle dump request, sampled only when idle
//   abort_i        terminate the dump in progress
//   first_idx_i    first register index, captured on accepted start
//   last_idx_i     last register index, captured on accepted start
//   core_rd_req_i  core wants the read port this cycle (has priority)
//   core_stall_o   core read port withheld this cycle (forced grab)
//   rf_sel_o       read-port address mux driven by rf_addr_o
//   rf_addr_o      register index presented to the read port
//   rf_data_i      read-port data, valid READ_LAT cycles after the grant
//   frame_o        {data[31:0], 3'b000, index[4:0]}
//   frame_valid_o  frame_o holds a valid frame
//   frame_ready_i  downstream accepts frame_o
//   busy_o         high whenever not idle
//   done_o         one-cycle pulse on normal completion

module reg_dump_ctrl #(
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [4:0]  first_idx_i,
  input  logic [4:0]  last_idx_i,
  input  logic        core_rd_req_i,
  output logic        core_stall_o,
  output logic        rf_sel_o,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_data_i,
  output logic [39:0] frame_o,
  output logic        frame_valid_o,
  input  logic        frame_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t      state_q;
  logic [4:0]  cur_idx_q;
  logic [4:0]  end_idx_q;
  logic [7:0]  starve_q;
  logic [1:0]  wait_cnt_q;
  logic [39:0] frame_q;
  logic        frame_valid_q;
  logic        busy_q;
  logic        done_q;

  logic        force_grab;
  logic        grant;

  // The grant depends on the core's request in the same cycle, so the
  // read-port controls are decoded from the state register plus that input.
  assign force_grab = (state_q == ST_REQ) && (starve_q == 8'(STARVE_MAX));
  assign grant      = (state_q == ST_REQ) && (!core_rd_req_i || force_grab);

  assign rf_sel_o      = grant;
  assign rf_addr_o     = grant ? cur_idx_q : 5'd0;
  assign core_stall_o  = force_grab;
  assign frame_o       = frame_q;
  assign frame_valid_o = frame_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      cur_idx_q     <= 5'd0;
      end_idx_q     <= 5'd0;
      starve_q      <= 8'd0;
      wait_cnt_q    <= 2'd0;
      frame_q       <= 40'd0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else if (abort_i && (state_q != ST_IDLE)) begin
      // Abort wins over any handshake in flight; no done pulse follows.
      state_q       <= ST_IDLE;
      starve_q      <= 8'd0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            cur_idx_q <= first_idx_i;
            end_idx_q <= last_idx_i;
            starve_q  <= 8'd0;
            busy_q    <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (grant) begin
            starve_q   <= 8'd0;
            wait_cnt_q <= 2'd0;
            state_q    <= ST_WAIT;
          end else begin
            starve_q <= starve_q + 8'd1;
          end
        end
        ST_WAIT: begin
          // Last wait cycle is exactly READ_LAT cycles after the grant,
          // which is when rf_data_i carries the requested register.
          if (wait_cnt_q == 2'(READ_LAT - 1)) begin
            frame_q       <= {rf_data_i, 3'b000, cur_idx_q};
            frame_valid_q <= 1'b1;
            state_q       <= ST_SEND;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        ST_SEND: begin
          if (frame_ready_i) begin
            frame_valid_q <= 1'b0;
            if (cur_idx_q == end_idx_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              cur_idx_q <= cur_idx_q + 5'd1;
              state_q   <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q       <= ST_IDLE;
          frame_valid_q <= 1'b0;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 The block SHALL have parameter READ_LAT, default 1: cycles from RF_ADDR presented to RF_DATA valid (legal 1..4).
REQ-002 The block SHALL have parameter STARVE_MAX, default 8: consecutive denied port-request cycles before the block forces a port grab (legal 1..255).
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 START  in  1  single-cycle dump request; sampled only in IDLE.
REQ-006 ABORT  in  1  terminate the dump in progress.
REQ-007 FIRST_IDX  in  5  first register index of the dump range; captured on accepted START.
REQ-008 LAST_IDX  in  5  last register index of the dump range; captured on accepted START.
REQ-009 CORE_RD_REQ  in  1  core requires the shared register-file read port this cycle.
REQ-010 CORE_STALL  out  1  core read port withheld this cycle; core holds its request.
REQ-011 RF_SEL  out  1  1 = read-port address mux driven by RF_ADDR.
REQ-012 RF_ADDR  out  5  register index presented to the read port.
REQ-013 RF_DATA  in  32  read-port data, valid READ_LAT cycles after RF_SEL=1.
REQ-014 FRAME  out  40  {data[31:0], 3'b000, index[4:0]}.
REQ-015 FRAME_VALID  out  1  FRAME holds a valid frame.
REQ-016 FRAME_READY  in  1  downstream accepts FRAME when FRAME_VALID=1.
REQ-017 BUSY  out  1  high in every state except IDLE.
REQ-018 DONE  out  1  one-cycle pulse on normal completion.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT, SEND, and DONE.
REQ-020 IDLE: START=1 SHALL capture FIRST_IDX into cur_idx and LAST_IDX into end_idx, then go to REQ.
REQ-021 REQ with CORE_RD_REQ=0: the block SHALL drive RF_SEL=1 and RF_ADDR=cur_idx for exactly one cycle, then go to WAIT.
REQ-022 REQ with CORE_RD_REQ=1: the core SHALL have priority; the block stays in REQ, RF_SEL=0, and increments starve_cnt.
REQ-023 When starve_cnt reaches STARVE_MAX, the block SHALL drive RF_SEL=1 and CORE_STALL=1 for one cycle regardless of CORE_RD_REQ, clear starve_cnt, and go to WAIT.
REQ-024 starve_cnt SHALL clear on every grant.
REQ-025 CORE_STALL SHALL be 0 in all other cycles.
REQ-026 WAIT SHALL last READ_LAT cycles, then latch {RF_DATA, 3'b000, cur_idx} into FRAME and go to SEND.
REQ-027 SEND SHALL hold FRAME_VALID=1 with FRAME stable until FRAME_READY=1.
REQ-028 On the handshake cycle, if cur_idx==end_idx the block SHALL go to DONE; otherwise it SHALL set cur_idx=cur_idx+1 mod 32 and go to REQ.
REQ-029 Wrap-around: FIRST_IDX>LAST_IDX SHALL dump FIRST..31 then 0..LAST. FIRST_IDX==LAST_IDX SHALL dump exactly one frame.
REQ-030 Index 0 SHALL be dumped like any other index, with data as returned by RF_DATA.
REQ-031 DONE SHALL assert DONE=1 for one cycle, then go to IDLE.
REQ-032 START while BUSY=1 SHALL be ignored.
REQ-033 ABORT=1 in any non-IDLE state SHALL go to IDLE next cycle, drop FRAME_VALID and RF_SEL, and suppress the DONE pulse. ABORT takes precedence over a simultaneous handshake.
REQ-034 FRAME_VALID SHALL be 1 only in SEND.
REQ-035 RF_SEL SHALL be 1 only in the grant cycle.
REQ-036 Throughput with no contention, READ_LAT=1, and FRAME_READY held high SHALL be one frame per 3 cycles.

Reset
REQ-037 RESET=1 at a rising edge SHALL force IDLE and set starve_cnt=0, cur_idx=0, end_idx=0, FRAME=0, and FRAME_VALID, RF_SEL, RF_ADDR, CORE_STALL, BUSY, DONE all 0, overriding START and ABORT.
REQ-038 RESET mid-dump SHALL abandon the dump with no DONE pulse.

Verification
REQ-039 FIRST=3, LAST=5, FRAME_READY=1, no core traffic -> frames for index 3,4,5 (FRAME[4:0]=3,4,5; FRAME[39:8]=reg value) at 3-cycle spacing, DONE pulse 1 cycle after the third handshake.
REQ-040 FIRST=30, LAST=1 -> four frames with indices 30,31,0,1 in order; index-0 frame data=0.
REQ-041 CORE_RD_REQ held 1, STARVE_MAX=8 -> RF_SEL=0 for 8 cycles, then one cycle of RF_SEL=1 with CORE_STALL=1; the frame then completes.
REQ-042 FRAME_READY low for 5 cycles in SEND -> FRAME_VALID stays 1 and FRAME is unchanged across all 5 cycles; the dump advances only after READY=1.
REQ-043 ABORT during second SEND of a 4-register dump -> IDLE next cycle, FRAME_VALID=0, no DONE pulse; a new START is then accepted.
REQ-044 RESET asserted in WAIT -> all outputs 0 next cycle; a START pulse with RESET=1 is ignored.
